// File: rtl/register_bank_ram.sv
// register_bank_ram
// Banked CPU register file: one set of 2^REG_BITS byte registers per
// interrupt level, addressed as {level, register}. Registers are stored as
// even/odd pairs in two banks so a word (big-endian pair) access touches one
// row of each bank. Two registered read ports, one write port, write-first
// bypass resolved per byte. A sweep after reset fills every row with
// INIT_VALUE; while it runs the write port is ignored and reads return 0.
//
// Ports
//   clock, reset            sole clock, synchronous active-high reset
//   level                   bank (interrupt level) for all ports this cycle
//   rd_{a,b}_addr/_word     read register select, 1 = word read of pair
//   rd_{a,b}_data           registered read data ({0,byte} or {even,odd})
//   wr_en/wr_word/wr_addr   write strobe, word select, register select
//   wr_data                 word: [hi]->even, [lo]->odd; byte: [lo] only
//   busy                    init sweep in progress
module register_bank_ram #(
    parameter int unsigned          DATA_WIDTH = 8,
    parameter int unsigned          LEVEL_BITS = 4,
    parameter int unsigned          REG_BITS   = 4,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = DATA_WIDTH'(8'hfe)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [LEVEL_BITS-1:0]   level,
    input  logic [REG_BITS-1:0]     rd_a_addr,
    input  logic                    rd_a_word,
    input  logic [REG_BITS-1:0]     rd_b_addr,
    input  logic                    rd_b_word,
    output logic [2*DATA_WIDTH-1:0] rd_a_data,
    output logic [2*DATA_WIDTH-1:0] rd_b_data,
    input  logic                    wr_en,
    input  logic                    wr_word,
    input  logic [REG_BITS-1:0]     wr_addr,
    input  logic [2*DATA_WIDTH-1:0] wr_data,
    output logic                    busy
);

    localparam int unsigned ROW_BITS = LEVEL_BITS + REG_BITS - 1;
    localparam int unsigned ROWS     = 1 << ROW_BITS;
    localparam int unsigned WORD_W   = 2 * DATA_WIDTH;

    logic [DATA_WIDTH-1:0] mem_even_q [ROWS];
    logic [DATA_WIDTH-1:0] mem_odd_q  [ROWS];

    logic [ROW_BITS-1:0]   sweep_row_q;
    logic                  busy_q;
    logic [WORD_W-1:0]     rd_a_q, rd_b_q;

    // User write decode (shared by memory write and bypass)
    logic [ROW_BITS-1:0]   wr_row_c;
    logic                  usr_we_even_c, usr_we_odd_c;
    logic [DATA_WIDTH-1:0] usr_wd_even_c, usr_wd_odd_c;

    // Memory write port (sweep or user)
    logic [ROW_BITS-1:0]   mem_row_c;
    logic                  mem_we_even_c, mem_we_odd_c;
    logic [DATA_WIDTH-1:0] mem_wd_even_c, mem_wd_odd_c;

    // Read port bank selects and bypassed bytes
    logic [ROW_BITS-1:0]   rd_a_row_c, rd_b_row_c;
    logic [DATA_WIDTH-1:0] a_even_c, a_odd_c, b_even_c, b_odd_c;
    logic [WORD_W-1:0]     rd_a_next_c, rd_b_next_c;

    // Format a read from the (already bypassed) even/odd bytes of a pair.
    function automatic logic [WORD_W-1:0] fmt_read(
        input logic                  odd_sel,
        input logic                  word,
        input logic [DATA_WIDTH-1:0] ev,
        input logic [DATA_WIDTH-1:0] od
    );
        logic [WORD_W-1:0] r;
        if (word) begin
            r = {ev, od};
        end else if (odd_sel) begin
            r = {{DATA_WIDTH{1'b0}}, od};
        end else begin
            r = {{DATA_WIDTH{1'b0}}, ev};
        end
        return r;
    endfunction

    // User write decode; ignored during sweep and reset
    always_comb begin
        wr_row_c      = ROW_BITS'({level, wr_addr} >> 1);
        usr_we_even_c = wr_en && !busy_q && !reset && (wr_word || !wr_addr[0]);
        usr_we_odd_c  = wr_en && !busy_q && !reset && (wr_word ||  wr_addr[0]);
        usr_wd_even_c = wr_word ? wr_data[WORD_W-1:DATA_WIDTH] : wr_data[DATA_WIDTH-1:0];
        usr_wd_odd_c  = wr_data[DATA_WIDTH-1:0];
    end

    // Memory write mux: sweep owns both banks while busy
    always_comb begin
        mem_row_c     = wr_row_c;
        mem_we_even_c = usr_we_even_c;
        mem_we_odd_c  = usr_we_odd_c;
        mem_wd_even_c = usr_wd_even_c;
        mem_wd_odd_c  = usr_wd_odd_c;
        if (busy_q) begin
            mem_row_c     = sweep_row_q;
            mem_we_even_c = !reset;
            mem_we_odd_c  = !reset;
            mem_wd_even_c = INIT_VALUE;
            mem_wd_odd_c  = INIT_VALUE;
        end
    end

    // Storage banks; contents defined only by the sweep and user writes
    always_ff @(posedge clock) begin
        if (mem_we_even_c) begin
            mem_even_q[mem_row_c] <= mem_wd_even_c;
        end
        if (mem_we_odd_c) begin
            mem_odd_q[mem_row_c] <= mem_wd_odd_c;
        end
    end

    // Port A: per-byte write-first bypass
    always_comb begin
        rd_a_row_c  = ROW_BITS'({level, rd_a_addr} >> 1);
        a_even_c    = (usr_we_even_c && (rd_a_row_c == wr_row_c)) ? usr_wd_even_c
                                                                  : mem_even_q[rd_a_row_c];
        a_odd_c     = (usr_we_odd_c && (rd_a_row_c == wr_row_c))  ? usr_wd_odd_c
                                                                  : mem_odd_q[rd_a_row_c];
        rd_a_next_c = fmt_read(rd_a_addr[0], rd_a_word, a_even_c, a_odd_c);
    end

    // Port B: per-byte write-first bypass
    always_comb begin
        rd_b_row_c  = ROW_BITS'({level, rd_b_addr} >> 1);
        b_even_c    = (usr_we_even_c && (rd_b_row_c == wr_row_c)) ? usr_wd_even_c
                                                                  : mem_even_q[rd_b_row_c];
        b_odd_c     = (usr_we_odd_c && (rd_b_row_c == wr_row_c))  ? usr_wd_odd_c
                                                                  : mem_odd_q[rd_b_row_c];
        rd_b_next_c = fmt_read(rd_b_addr[0], rd_b_word, b_even_c, b_odd_c);
    end

    // Sweep control: busy clears on the edge that writes the last row
    always_ff @(posedge clock) begin
        if (reset) begin
            sweep_row_q <= '0;
            busy_q      <= 1'b1;
        end else if (busy_q) begin
            sweep_row_q <= sweep_row_q + ROW_BITS'(1);
            if (sweep_row_q == ROW_BITS'(ROWS - 1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    // Read data registers; held at zero while sweeping
    always_ff @(posedge clock) begin
        if (reset || busy_q) begin
            rd_a_q <= '0;
            rd_b_q <= '0;
        end else begin
            rd_a_q <= rd_a_next_c;
            rd_b_q <= rd_b_next_c;
        end
    end

    assign rd_a_data = rd_a_q;
    assign rd_b_data = rd_b_q;
    assign busy      = busy_q;

endmodule

// File: doc/register_bank_ram.md
# register_bank_ram

Parametrised successor to the single-port CPU register RAM: a banked register file holding one set of 2^REG_BITS byte registers per interrupt level, addressed as {level, register}. Two synchronous read ports and one write port, each byte- or word-wide (even/odd big-endian register pair), with write-first bypass. A reset-driven sweep fills every entry with INIT_VALUE. Sits between the microsequencer's register-select fields and the ALU operand latches.

## Interface
- DATA_WIDTH, 8: bits per register.
- LEVEL_BITS, 4: level select width; 2^LEVEL_BITS banks.
- REG_BITS, 4: register select width (≥1); 2^REG_BITS registers per level.
- INIT_VALUE, 8'hfe: value written to every entry by the init sweep.
- clock  in  1  sole clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- level  in  LEVEL_BITS  bank for all three ports this cycle.
- rd_a_addr, rd_b_addr  in  REG_BITS  read register selects.
- rd_a_word, rd_b_word  in  1  1 = word read of pair (addr[0] ignored).
- rd_a_data, rd_b_data  out  2*DATA_WIDTH  registered read data.
- wr_en  in  1  write strobe.
- wr_word  in  1  1 = word write of pair (wr_addr[0] ignored).
- wr_addr  in  REG_BITS  write register select.
- wr_data  in  2*DATA_WIDTH  word: [hi]→even reg, [lo]→odd reg; byte: [lo] only.
- busy  out  1  init sweep in progress; ports inert.

## Operation
- Storage: two banks (even, odd), each 2^(LEVEL_BITS+REG_BITS-1) x DATA_WIDTH; row = {level, addr[REG_BITS-1:1]}, bank = addr[0].
- Byte write: writes bank addr[0] at row. Word write: both banks, same row.
- Byte read: data = {0, byte}. Word read: data = {even, odd} (big-endian).
- Bypass: read in same cycle as write to an overlapping byte returns new byte(s); resolved per byte (byte write + word read of same pair returns new byte merged with old partner byte).
- Ports A and B independent; same address on both returns identical data.
- Init sweep: reset loads row counter 0 and sets busy. Each non-reset cycle while busy writes INIT_VALUE to both banks at counter row, counter increments; after last row, busy clears.
- While busy: wr_en ignored, rd_*_data held at 0.
- Reset mid-sweep or mid-operation: counter returns to 0, sweep restarts; contents not otherwise guaranteed until busy clears.
- No memory contents depend on simulator initial blocks; only the sweep defines them.

## Timing
- Reset values (edge with reset=1): rd_a_data=0, rd_b_data=0, busy=1.
- Sweep length: ROWS = 2^(LEVEL_BITS+REG_BITS-1) cycles after reset falls (128 at defaults); busy low from the edge ending the cycle that wrote row ROWS-1.
- First usable cycle: first cycle with busy=0; read issued there appears on rd_*_data after next edge.
- Read latency: 1 cycle (address/level/word sampled at edge N, data valid after edge N).
- Write: committed at the edge it is sampled; visible to reads issued same cycle (bypass) and after.
- level applies to reads and write of the same cycle; change takes effect immediately.

## Test plan
- Reset 1 cycle, release: busy high exactly 128 cycles; then byte reads of level 0 reg 0 and level 15 reg 15 return 16'h00fe; word read of reg 2 returns 16'hfefe.
- Level 3, word write reg 4 = 16'h1234; next cycle word read reg 5 returns 16'h1234, byte read reg 4 returns 16'h0012, reg 5 returns 16'h0034; level 2 reg 4 still 16'h00fe.
- Same cycle: byte write level 1 reg 7 = 8'hab, port A word read reg 6, port B byte read reg 7 -> A = 16'hfeab, B = 16'h00ab (bypass).
- wr_en with reads during busy: no effect; read data 0 throughout; after sweep target reg reads 16'h00fe.
- Reset asserted at sweep cycle 50 after writes pending: busy stays high, sweep restarts from row 0, busy drops 128 cycles after the second release.
- Parameters DATA_WIDTH=16, LEVEL_BITS=2, REG_BITS=3, INIT_VALUE=16'h0000: sweep 16 cycles; word write reg 1 = 32'hdeadbeef, word read returns 32'hdeadbeef.
